// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if: frame strobe, button input and the registered game
// state consumed by the pixel renderer and the 7-segment driver.
interface flappy_game_ctrl_if #(
    parameter int NUM_COLS = 4
);
    logic                    frame_tick;
    logic                    flap;
    logic [1:0]              state;
    logic [8:0]              bird_y;
    logic [NUM_COLS*11-1:0]  col_x;
    logic [NUM_COLS*9-1:0]   gap_top;
    logic [13:0]             score;
    logic                    collided;

    modport master (
        output frame_tick, flap,
        input  state, bird_y, col_x, gap_top, score, collided
    );

    modport slave (
        input  frame_tick, flap,
        output state, bird_y, col_x, gap_top, score, collided
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: frame-rate game sequencer (bird physics, scrolling
// columns, hit test, score). Everything advances on frame_tick.
// Build option: FLAPPY_INVINCIBLE_EN -- nothing can kill the bird; floor and
// ceiling still clamp its position.
//
// state | meaning
// IDLE  | bird parked at START_Y, columns at start positions, waiting for a flap
// PLAY  | physics, scrolling, scoring and hit test on every frame_tick
// DEAD  | positions frozen for HOLD_FRAMES ticks, score left on display
module flappy_game_ctrl #(
    parameter int NUM_COLS    = 4,
    parameter int COL_SPACING = 240,
    parameter int START_X     = 200,
    parameter int COL_W       = 50,
    parameter int GAP_H       = 100,
    parameter int BIRD_X      = 100,
    parameter int BIRD_W      = 20,
    parameter int BIRD_H      = 30,
    parameter int START_Y     = 240,
    parameter int SCREEN_H    = 480,
    parameter int FLAP_VEL    = 6,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 8,
    parameter int HOLD_FRAMES = 60
) (
    input  logic              clk,
    input  logic              reset,
    flappy_game_ctrl_if.slave bus
);
    localparam int PERIOD = NUM_COLS * COL_SPACING;
    localparam int PC_W   = $clog2(NUM_COLS + 1);
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [10:0]        X_WRAP    = 11'(PERIOD - 1);
    localparam logic [11:0]        COL_W_U   = 12'(COL_W);
    localparam logic [11:0]        GAP_H_U   = 12'(GAP_H);
    localparam logic [11:0]        BIRD_X_U  = 12'(BIRD_X);
    localparam logic [11:0]        BIRD_XR_U = 12'(BIRD_X + BIRD_W);
    localparam logic [11:0]        BIRD_H_U  = 12'(BIRD_H);
    localparam logic signed [9:0]  Y_START   = 10'(START_Y);
    localparam logic signed [9:0]  Y_LAUNCH  = 10'(START_Y - FLAP_VEL);
    localparam logic signed [9:0]  Y_MAX     = 10'(SCREEN_H - BIRD_H);
    localparam logic signed [4:0]  VEL_FLAP  = 5'(-FLAP_VEL);
    localparam logic signed [4:0]  VEL_GRAV  = 5'(GRAVITY);
    localparam logic signed [4:0]  VEL_CAP   = 5'(MAX_FALL);
    localparam logic [8:0]         GAP_BASE  = 9'd40;
    localparam logic [13:0]        SCORE_MAX = 14'd9999;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t              st_q;
    logic signed [9:0]   y_q;
    logic signed [4:0]   vel_q;
    logic [10:0]         col_x_q  [NUM_COLS];
    logic [8:0]          gap_q    [NUM_COLS];
    logic [13:0]         score_q;
    logic                collided_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                flap_d;
    logic                flap_req;
    logic [7:0]          lfsr;

    logic                flap_rise;
    logic                req_now;
    logic                hit;
    logic                col_hit;
    logic                x_hit;
    logic                in_gap;
    logic [11:0]         x_ext;
    logic [11:0]         g_ext;
    logic [11:0]         y_ext;
    logic signed [4:0]   vel_play;
    logic signed [9:0]   y_sum;
    logic signed [9:0]   y_play;
    logic [10:0]         x_play   [NUM_COLS];
    logic [8:0]          gap_play [NUM_COLS];
    logic [PC_W-1:0]     pass_cnt;
    logic [14:0]         score_sum;
    logic [13:0]         score_play;
    logic [NUM_COLS*11-1:0] col_x_flat;
    logic [NUM_COLS*9-1:0]  gap_flat;

    assign flap_rise = bus.flap & ~flap_d;
    assign req_now   = flap_req | flap_rise;

    // Button edge capture and the free-running gap LFSR (taps 8,6,5,4).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flap_d   <= 1'b0;
            flap_req <= 1'b0;
            lfsr     <= 8'hA5;
        end else begin
            flap_d <= bus.flap;
            lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (bus.frame_tick)
                flap_req <= 1'b0;
            else if (flap_rise)
                flap_req <= 1'b1;
        end
    end

    // Next-frame PLAY values and the hit test on the currently registered positions.
    always_comb begin
        hit      = 1'b0;
        col_hit  = 1'b0;
        x_hit    = 1'b0;
        in_gap   = 1'b0;
        x_ext    = '0;
        g_ext    = '0;
        pass_cnt = '0;
        y_ext    = {3'b000, y_q[8:0]};

        if (req_now)
            vel_play = VEL_FLAP;
        else if (vel_q > VEL_CAP - VEL_GRAV)
            vel_play = VEL_CAP;
        else
            vel_play = vel_q + VEL_GRAV;

        y_sum = y_q + $signed({{5{vel_play[4]}}, vel_play});
        if (y_sum < 10'sd0)
            y_play = '0;
        else if (y_sum > Y_MAX)
            y_play = Y_MAX;
        else
            y_play = y_sum;

        for (int i = 0; i < NUM_COLS; i++) begin
            x_ext  = {1'b0, col_x_q[i]};
            g_ext  = {3'b000, gap_q[i]};
            x_hit  = (x_ext + COL_W_U > BIRD_X_U) && (x_ext < BIRD_XR_U);
            in_gap = (y_ext >= g_ext) && (y_ext + BIRD_H_U <= g_ext + GAP_H_U);
            if (x_hit && !in_gap)
                col_hit = 1'b1;
            if (col_x_q[i] == '0) begin
                x_play[i]   = X_WRAP;
                gap_play[i] = GAP_BASE + {1'b0, lfsr};
            end else begin
                x_play[i]   = col_x_q[i] - 11'd1;
                gap_play[i] = gap_q[i];
            end
            if ({1'b0, x_play[i]} + COL_W_U == BIRD_X_U)
                pass_cnt = pass_cnt + PC_W'(1);
        end

        score_sum  = {1'b0, score_q} + 15'(pass_cnt);
        score_play = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];

`ifdef FLAPPY_INVINCIBLE_EN
        hit = 1'b0;
`else
        hit = col_hit || (y_q <= 10'sd0) || (y_q >= Y_MAX);
`endif
    end

    // Game FSM: all positions, score and the collided pulse advance on frame_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= IDLE;
            y_q        <= Y_START;
            vel_q      <= '0;
            score_q    <= '0;
            collided_q <= 1'b0;
            hold_q     <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                col_x_q[i] <= 11'(START_X + i * COL_SPACING);
                gap_q[i]   <= 9'(40 + 40 * i);
            end
        end else begin
            collided_q <= 1'b0;
            if (bus.frame_tick) begin
                case (st_q)
                    IDLE: begin
                        if (req_now) begin
                            st_q    <= PLAY;
                            score_q <= '0;
                            vel_q   <= VEL_FLAP;
                            y_q     <= Y_LAUNCH;
                        end
                    end
                    PLAY: begin
                        if (hit) begin
                            st_q       <= DEAD;
                            collided_q <= 1'b1;
                            hold_q     <= HOLD_LOAD;
                        end else begin
                            vel_q   <= vel_play;
                            y_q     <= y_play;
                            score_q <= score_play;
                            col_x_q <= x_play;
                            gap_q   <= gap_play;
                        end
                    end
                    DEAD: begin
                        if (hold_q == '0) begin
                            st_q  <= IDLE;
                            y_q   <= Y_START;
                            vel_q <= '0;
                            for (int i = 0; i < NUM_COLS; i++) begin
                                col_x_q[i] <= 11'(START_X + i * COL_SPACING);
                                gap_q[i]   <= 9'(40 + 40 * i);
                            end
                        end else begin
                            hold_q <= hold_q - HOLD_W'(1);
                        end
                    end
                    default: st_q <= IDLE;
                endcase
            end
        end
    end

    // Flatten the column registers onto the packed output buses.
    always_comb begin
        col_x_flat = '0;
        gap_flat   = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            col_x_flat[11*i +: 11] = col_x_q[i];
            gap_flat[9*i +: 9]     = gap_q[i];
        end
    end

    assign bus.state    = st_q;
    assign bus.bird_y   = y_q[8:0];
    assign bus.col_x    = col_x_flat;
    assign bus.gap_top  = gap_flat;
    assign bus.score    = score_q;
    assign bus.collided = collided_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed vectors and scripted games for flappy_game_ctrl.
module tb_flappy_game_ctrl;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_DEAD = 2'b10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    flappy_game_ctrl_if #(.NUM_COLS(4)) bus ();

    flappy_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        bit         flap;
        logic [1:0] st;
        int         y;
        int         x0;
        int         sc;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int colx(input int i);
        return int'(bus.col_x[11*i +: 11]);
    endfunction

    function automatic int gapt(input int i);
        return int'(bus.gap_top[9*i +: 9]);
    endfunction

    // One frame: optional flap pulse before the tick, or a flap edge on the tick cycle itself.
    task automatic tick(input bit fl, input bit same);
        if (fl && !same) begin
            bus.flap = 1'b1;
            @(negedge clk);
            bus.flap = 1'b0;
        end
        if (same)
            bus.flap = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.flap       = 1'b0;
    endtask

    // Keep the bird inside the gap of the nearest column still ahead of it.
    task automatic steer_tick();
        int best;
        int g;
        best = 2000;
        g    = 40;
        for (int i = 0; i < 4; i++) begin
            if (colx(i) > 50 && colx(i) < best) begin
                best = colx(i);
                g    = gapt(i);
            end
        end
        tick(int'(bus.bird_y) > g + 30, 1'b0);
    endtask

    initial begin
        int  alive;
        int  died;
        int  g0;

        for (int i = 0; i < 10; i++)
            vecs[i] = '{1'b0, ST_IDLE, 240, 200, 0};
        vecs[10] = '{1'b1, ST_PLAY, 234, 200, 0};
        vecs[11] = '{1'b0, ST_PLAY, 229, 199, 0};
        vecs[12] = '{1'b0, ST_PLAY, 225, 198, 0};
        vecs[13] = '{1'b0, ST_PLAY, 222, 197, 0};
        vecs[14] = '{1'b0, ST_PLAY, 220, 196, 0};
        vecs[15] = '{1'b0, ST_PLAY, 219, 195, 0};

        bus.frame_tick = 1'b0;
        bus.flap       = 1'b0;

        // Ticks and flaps while in reset must be ignored.
        repeat (3) @(negedge clk);
        bus.frame_tick = 1'b1;
        bus.flap       = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.flap       = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("rst_state", bus.state, ST_IDLE);
        check("rst_y", bus.bird_y, 240);
        check("rst_score", bus.score, 0);
        check("rst_collided", bus.collided, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_x%0d", i), colx(i), 200 + 240 * i);
            check($sformatf("rst_gap%0d", i), gapt(i), 40 + 40 * i);
        end

        // Idle ticks, launch, then free flight upward.
        for (int i = 0; i < 16; i++) begin
            tick(vecs[i].flap, 1'b0);
            check($sformatf("vec%0d_state", i), bus.state, vecs[i].st);
            check($sformatf("vec%0d_y", i), bus.bird_y, vecs[i].y);
            check($sformatf("vec%0d_x0", i), colx(0), vecs[i].x0);
            check($sformatf("vec%0d_score", i), bus.score, vecs[i].sc);
        end

        // Fall to the floor clamp, then die on the following tick.
        for (int k = 6; k <= 38; k++)
            tick(1'b0, 1'b0);
        check("fall_y447", bus.bird_y, 447);
        check("fall_x0", colx(0), 162);
        check("fall_state", bus.state, ST_PLAY);
        tick(1'b0, 1'b0);
        check("floor_clamp_y", bus.bird_y, 450);
        check("floor_clamp_state", bus.state, ST_PLAY);
        check("floor_clamp_collided", bus.collided, 0);
        tick(1'b0, 1'b0);
        check("floor_dead_state", bus.state, ST_DEAD);
        check("floor_collided", bus.collided, 1);
        check("floor_frozen_x0", colx(0), 161);
        check("floor_frozen_y", bus.bird_y, 450);
        @(negedge clk);
        check("collided_one_cycle", bus.collided, 0);

        // Hold in DEAD; a flap during DEAD must not start the next game.
        repeat (59) tick(1'b0, 1'b0);
        check("hold59_state", bus.state, ST_DEAD);
        tick(1'b1, 1'b0);
        check("hold60_state", bus.state, ST_IDLE);
        check("hold60_y", bus.bird_y, 240);
        check("hold60_x0", colx(0), 200);
        check("hold60_score", bus.score, 0);
        tick(1'b0, 1'b0);
        check("dead_flap_discard", bus.state, ST_IDLE);

        // Game A: same-cycle flap, then steer through three columns.
        tick(1'b1, 1'b0);
        check("a_start_state", bus.state, ST_PLAY);
        tick(1'b0, 1'b0);
        check("a_t1_y", bus.bird_y, 229);
        tick(1'b0, 1'b1);
        check("a_sameflap_y", bus.bird_y, 223);
        alive = 1;
        for (int n = 3; n <= 630 && alive == 1; n++) begin
            steer_tick();
            if (bus.state != ST_PLAY)
                alive = 0;
            else if (n == 150) begin
                check("a_n150_x0", colx(0), 50);
                check("a_n150_score", bus.score, 1);
            end else if (n == 200) begin
                check("a_n200_x0", colx(0), 0);
            end else if (n == 201) begin
                check("a_wrap_x0", colx(0), 959);
                g0 = gapt(0);
                check("a_wrap_gap_range", (g0 >= 40 && g0 <= 295), 1);
                check("a_wrap_score", bus.score, 1);
            end else if (n == 390) begin
                check("a_n390_score", bus.score, 2);
            end else if (n == 630) begin
                check("a_n630_score", bus.score, 3);
            end
        end
        check("a_alive", alive, 1);

        // Reset mid-PLAY with a pending flap request.
        bus.flap = 1'b1;
        @(negedge clk);
        bus.flap = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("midrst_state", bus.state, ST_IDLE);
        check("midrst_score", bus.score, 0);
        check("midrst_x0", colx(0), 200);
        check("midrst_y", bus.bird_y, 240);
        check("midrst_collided", bus.collided, 0);
        reset = 1'b1;
        @(negedge clk);
        tick(1'b0, 1'b0);
        check("midrst_req_cleared", bus.state, ST_IDLE);

        // Game B: score one column, crash, and keep the score through DEAD and IDLE.
        tick(1'b1, 1'b0);
        check("b_start_y", bus.bird_y, 234);
        alive = 1;
        for (int n = 1; n <= 150 && alive == 1; n++) begin
            steer_tick();
            if (bus.state != ST_PLAY)
                alive = 0;
        end
        check("b_alive", alive, 1);
        check("b_n150_x0", colx(0), 50);
        check("b_n150_score", bus.score, 1);
        died = 0;
        for (int n = 0; n < 200 && died == 0; n++) begin
            tick(1'b0, 1'b0);
            if (bus.state != ST_PLAY)
                died = 1;
        end
        check("b_dead_state", bus.state, ST_DEAD);
        check("b_collided", bus.collided, 1);
        check("b_dead_score", bus.score, 1);
        @(negedge clk);
        check("b_collided_low", bus.collided, 0);
        repeat (59) tick(1'b0, 1'b0);
        check("b_hold59_state", bus.state, ST_DEAD);
        tick(1'b0, 1'b0);
        check("b_idle_state", bus.state, ST_IDLE);
        check("b_idle_score_kept", bus.score, 1);
        check("b_idle_x0", colx(0), 200);
        tick(1'b1, 1'b0);
        check("b_restart_state", bus.state, ST_PLAY);
        check("b_restart_score", bus.score, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Frame-rate game sequencer for the Flappy VGA datapath. Owns the IDLE/PLAY/DEAD state machine, the bird's vertical physics, the scrolling column positions and gap heights, collision detection and the score. Advances once per `frame_tick`, the screen-end pulse from the VGA timing generator. The pixel renderer and 7-segment driver consume its registered outputs.

## Interface
- NUM_COLS, 4, number of columns
- COL_SPACING, 240, px between column left edges; period P = NUM_COLS*COL_SPACING = 960
- START_X, 200, column 0 initial x; column i starts at START_X + i*COL_SPACING
- COL_W, 50, column width px
- GAP_H, 100, gap height px
- BIRD_X, 100, fixed bird left edge
- BIRD_W, 20, bird width; BIRD_H, 30, bird height
- START_Y, 240, bird top at IDLE
- SCREEN_H, 480, floor y
- FLAP_VEL, 6, upward speed set by flap (px/frame)
- GRAVITY, 1, velocity increment per frame; MAX_FALL, 8, velocity cap
- HOLD_FRAMES, 60, frames frozen in DEAD

- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, synchronous to clk
- flap  in  1  raw button level, already synchronised
- state  out  2  00 IDLE, 01 PLAY, 10 DEAD
- bird_y  out  9  bird top edge
- col_x  out  NUM_COLS*11  packed column left edges, column i at [11i+10:11i]
- gap_top  out  NUM_COLS*9  packed gap top rows
- score  out  14  binary, saturates at 9999
- collided  out  1  one-cycle pulse on PLAY→DEAD

## Operation
- Flap edge: rising edge of `flap` sets a sticky `flap_req`. `flap_req` is cleared on every `frame_tick`. An edge in the same cycle as `frame_tick` counts for that tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5 at reset, steps every clk. A new gap is computed as 40 + lfsr, giving a range of 40..295.
- IDLE: bird_y = START_Y, vel = 0, columns at initial x, gap_top[i] = 40 + 40*i, score held.
  - On a tick with flap_req: go to PLAY, score = 0, vel = -FLAP_VEL, y += vel.
- PLAY, each tick:
  - Evaluate the hit using the current registered values. Hit means bird y < 0-clamped top, or y + BIRD_H ≥ SCREEN_H, or overlap with any column.
  - Overlap condition: x-overlap of [BIRD_X, BIRD_X+BIRD_W) with [x, x+COL_W), and the bird is not fully inside [gap_top, gap_top+GAP_H).
  - On hit: go to DEAD, pulse `collided`, freeze all positions.
  - Otherwise:
    - vel = flap_req ? -FLAP_VEL : min(vel + GRAVITY, MAX_FALL).
    - y = clamp(y + vel, 0, SCREEN_H - BIRD_H); reaching 0 counts as a ceiling hit on the next tick.
    - Each column: x = (x == 0) ? P - 1 : x - 1. On wrap, gap_top = 40 + lfsr.
    - Score +1, saturating, for each column whose new x + COL_W == BIRD_X.
- DEAD: hold counter counts ticks. When it reaches HOLD_FRAMES, go to IDLE and reload the IDLE positions. score is held for display.
- Arithmetic: x is 11-bit unsigned, y is 10-bit signed internally and output as 9 bits, vel is 5-bit signed.

## Timing
- All outputs are registered and update on the clk edge where frame_tick = 1. They are valid from the next cycle until the next tick.
- Collision is detected on the tick after the overlapping positions were registered, so the latency is one frame.
- `collided` is high for exactly the one cycle after the PLAY→DEAD tick.
- frame_tick while reset is asserted: ignored.
- Reset mid-game: immediate return to the IDLE values, score = 0, flap_req = 0, hold counter = 0.
- A flap during DEAD is discarded; flap_req is cleared at each tick.
- Multiple columns passing the bird on the same tick: each adds 1.

## Configuration
- `FLAPPY_INVINCIBLE_EN` defined: column overlap is excluded from the hit. Floor and ceiling still clamp y but do not cause death, so the game stays in PLAY indefinitely while scoring continues.
- Not defined: full hit rule as above.

## Test plan
- Reset deasserted, 10 ticks with no flap → state = IDLE, bird_y = 240, col_x[0] = 200, score = 0.
- Flap, then tick → state = PLAY, bird_y = 234. Five further ticks with no flap → velocities −5..−1, bird_y = 219.
- PLAY with bird held in the gap, columns at initial x → on the 150th tick col_x[0] = 50 and score = 1. Column 0 wraps to 959 on the tick after x == 0.
- No flaps from START_Y → bird reaches floor clamp 450; next tick → collided pulse, state = DEAD. After 60 ticks → IDLE, score retained.
- Flap rising edge in the same cycle as frame_tick in PLAY → vel = −6 applied that tick.
- Reset asserted mid-PLAY at score 3 → next cycle: IDLE, score = 0, col_x[0] = 200, no collided pulse.
